// File: rtl/adaptive_threshold_stream.sv
// adaptive_threshold_stream
//
// Streams a 2**WIDTH_BITS x 2**HEIGHT_BITS image through a per-pixel threshold.
// Image and threshold memories are read in lockstep in raster order (column fastest).
// Each pixel is binarised against (threshold - C), which saturates at zero.
// The result is pushed with its coordinate into a 2-entry output FIFO drained by a
// valid/ready handshake.
//
// Ports
//   clock, not_reset              rising-edge clock, asynchronous active-low reset
//   iStart, iC                    frame start (sampled in idle only), offset latched on start
//   oBusy, oDone                  busy outside idle, one-cycle end-of-frame pulse
//   oImageCol/Row, iImageData     image memory address / data (1-cycle read latency)
//   oThresholdCol/Row,
//   iThresholdData                threshold memory address / data (1-cycle read latency)
//   oResultCol/Row, oResultData   head-of-FIFO coordinate and binarised pixel
//   oResultValid, iResultReady    output handshake
//
// Configuration
//   ADAPTIVE_THRESHOLD_INVERT_EN  when defined, the output polarity is inverted
//                                 (1 iff pixel <= adjusted threshold); timing is unchanged.
module adaptive_threshold_stream #(
  parameter int unsigned WIDTH_BITS  = 8,
  parameter int unsigned HEIGHT_BITS = 8,
  parameter int unsigned PIX_BITS    = 8,
  parameter int unsigned C_BITS      = 5
) (
  input  logic                   clock,
  input  logic                   not_reset,
  input  logic                   iStart,
  input  logic [C_BITS-1:0]      iC,
  output logic                   oBusy,
  output logic                   oDone,
  output logic [WIDTH_BITS-1:0]  oImageCol,
  output logic [HEIGHT_BITS-1:0] oImageRow,
  input  logic [PIX_BITS-1:0]    iImageData,
  output logic [WIDTH_BITS-1:0]  oThresholdCol,
  output logic [HEIGHT_BITS-1:0] oThresholdRow,
  input  logic [PIX_BITS-1:0]    iThresholdData,
  output logic [WIDTH_BITS-1:0]  oResultCol,
  output logic [HEIGHT_BITS-1:0] oResultRow,
  output logic                   oResultData,
  output logic                   oResultValid,
  input  logic                   iResultReady
);

  localparam int unsigned EntryBits = WIDTH_BITS + HEIGHT_BITS + 1;

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

  state_e                 stateQ;
  logic [C_BITS-1:0]      cQ;
  logic [WIDTH_BITS-1:0]  colQ;
  logic [HEIGHT_BITS-1:0] rowQ;

  // One read in flight: its address was presented last cycle, its data is on the bus now.
  logic                   inFlightQ;
  logic [WIDTH_BITS-1:0]  flightColQ;
  logic [HEIGHT_BITS-1:0] flightRowQ;

  logic [EntryBits-1:0]   fifoQ [2];
  logic                   rdPtrQ;
  logic                   wrPtrQ;
  logic [1:0]             countQ;

  logic                   pop;
  logic                   push;
  logic                   issue;
  logic                   lastAddr;
  logic                   pixel;
  logic [2:0]             occupancy;
  logic [PIX_BITS-1:0]    cExt;
  logic [PIX_BITS-1:0]    adj;

  assign pop       = (countQ != 2'd0) && iResultReady;
  assign push      = inFlightQ;
  assign occupancy = {1'b0, countQ} + {2'b00, inFlightQ};
  // A new read lands in the FIFO two edges from now; only issue if a slot is guaranteed.
  assign issue     = (stateQ == StScan) && (occupancy < (3'd2 + {2'b00, pop}));
  assign lastAddr  = (&colQ) && (&rowQ);

  assign cExt = PIX_BITS'(cQ);
  assign adj  = (iThresholdData > cExt) ? (iThresholdData - cExt) : '0;

`ifdef ADAPTIVE_THRESHOLD_INVERT_EN
  assign pixel = (iImageData <= adj);
`else
  assign pixel = (iImageData > adj);
`endif

  // The address registers are the memory address outputs; they hold while stalled.
  assign oImageCol     = colQ;
  assign oImageRow     = rowQ;
  assign oThresholdCol = colQ;
  assign oThresholdRow = rowQ;

  assign {oResultCol, oResultRow, oResultData} = fifoQ[rdPtrQ];
  assign oResultValid = (countQ != 2'd0);

  // Control FSM with registered busy/done outputs.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      stateQ <= StIdle;
      cQ     <= '0;
      colQ   <= '0;
      rowQ   <= '0;
      oBusy  <= 1'b0;
      oDone  <= 1'b0;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (iStart) begin
            cQ     <= iC;
            colQ   <= '0;
            rowQ   <= '0;
            oBusy  <= 1'b1;
            stateQ <= StScan;
          end
        end
        StScan: begin
          if (issue) begin
            if (lastAddr) begin
              // Counters stay parked on the final address.
              stateQ <= StDrain;
            end else if (&colQ) begin
              colQ <= '0;
              rowQ <= rowQ + 1'b1;
            end else begin
              colQ <= colQ + 1'b1;
            end
          end
        end
        StDrain: begin
          // Leave once the FIFO empties on this edge and no read is outstanding.
          if (!inFlightQ && (countQ == {1'b0, pop})) begin
            oDone  <= 1'b1;
            stateQ <= StDone;
          end
        end
        StDone: begin
          oDone  <= 1'b0;
          oBusy  <= 1'b0;
          stateQ <= StIdle;
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

  // Read tracking: remembers the coordinate of the read whose data arrives next cycle.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      inFlightQ  <= 1'b0;
      flightColQ <= '0;
      flightRowQ <= '0;
    end else begin
      inFlightQ <= issue;
      if (issue) begin
        flightColQ <= colQ;
        flightRowQ <= rowQ;
      end
    end
  end

  // Two-entry output FIFO; simultaneous push and pop keep count and order.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      for (int i = 0; i < 2; i++) begin
        fifoQ[i] <= '0;
      end
      rdPtrQ <= 1'b0;
      wrPtrQ <= 1'b0;
      countQ <= 2'd0;
    end else begin
      if (push) begin
        fifoQ[wrPtrQ] <= {flightColQ, flightRowQ, pixel};
        wrPtrQ        <= ~wrPtrQ;
      end
      if (pop) begin
        rdPtrQ <= ~rdPtrQ;
      end
      countQ <= countQ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_adaptive_threshold_stream.sv
module tb_adaptive_threshold_stream;

  localparam int W    = 2;
  localparam int H    = 2;
  localparam int P    = 8;
  localparam int CB   = 5;
  localparam int Cols = 1 << W;
  localparam int Rows = 1 << H;
  localparam int N    = Cols * Rows;

`ifdef ADAPTIVE_THRESHOLD_INVERT_EN
  localparam int OnesC5 = 16;
  localparam int OnesC6 = 0;
`else
  localparam int OnesC5 = 0;
  localparam int OnesC6 = 16;
`endif

  logic          clock = 1'b0;
  logic          not_reset = 1'b0;
  logic          iStart = 1'b0;
  logic [CB-1:0] iC = '0;
  logic          oBusy, oDone;
  logic [W-1:0]  oImageCol, oThresholdCol, oResultCol;
  logic [H-1:0]  oImageRow, oThresholdRow, oResultRow;
  logic [P-1:0]  iImageData, iThresholdData;
  logic          oResultData, oResultValid;
  logic          iResultReady = 1'b0;

  adaptive_threshold_stream #(
    .WIDTH_BITS (W),
    .HEIGHT_BITS(H),
    .PIX_BITS   (P),
    .C_BITS     (CB)
  ) dut (
    .clock         (clock),
    .not_reset     (not_reset),
    .iStart        (iStart),
    .iC            (iC),
    .oBusy         (oBusy),
    .oDone         (oDone),
    .oImageCol     (oImageCol),
    .oImageRow     (oImageRow),
    .iImageData    (iImageData),
    .oThresholdCol (oThresholdCol),
    .oThresholdRow (oThresholdRow),
    .iThresholdData(iThresholdData),
    .oResultCol    (oResultCol),
    .oResultRow    (oResultRow),
    .oResultData   (oResultData),
    .oResultValid  (oResultValid),
    .iResultReady  (iResultReady)
  );

  always #5 clock = ~clock;

  // Synchronous-read memories: one-cycle latency.
  logic [P-1:0] imgMem [N];
  logic [P-1:0] thrMem [N];
  always @(posedge clock) begin
    iImageData     <= imgMem[{oImageRow, oImageCol}];
    iThresholdData <= thrMem[{oThresholdRow, oThresholdCol}];
  end

  logic [3*(W+H)+3:0] outVec;
  assign outVec = {oBusy, oDone, oImageCol, oImageRow, oThresholdCol, oThresholdRow,
                   oResultCol, oResultRow, oResultData, oResultValid};

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input bit ok, input string name, input int actual, input int required);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  // Reference model: expected output stream of a frame, straight from the pixel rule.
  typedef struct packed {
    logic [W-1:0] col;
    logic [H-1:0] row;
    logic         px;
  } exp_t;

  exp_t expQ[$];

  function automatic logic refPixel(input int img, input int thr, input int c);
    int adj;
    adj = (thr > c) ? thr - c : 0;
`ifdef ADAPTIVE_THRESHOLD_INVERT_EN
    return img <= adj;
`else
    return img > adj;
`endif
  endfunction

  task automatic queueFrame(input int c);
    exp_t e;
    for (int r = 0; r < Rows; r++) begin
      for (int cl = 0; cl < Cols; cl++) begin
        e.col = W'(cl);
        e.row = H'(r);
        e.px  = refPixel(int'(imgMem[r*Cols+cl]), int'(thrMem[r*Cols+cl]), c);
        expQ.push_back(e);
      end
    end
  endtask

  task automatic fillRandom(input int thrMax);
    for (int i = 0; i < N; i++) begin
      imgMem[i] = P'($urandom_range(0, 255));
      thrMem[i] = P'($urandom_range(0, thrMax));
    end
  endtask

  // Ready driver.
  int readyMode = 0;
  int phase = 0;
  initial forever begin
    @(posedge clock);
    #1;
    case (readyMode)
      0: iResultReady = 1'b1;
      1: begin
        iResultReady = ((phase % 4) == 0) || ((phase % 4) == 3);
        phase++;
      end
      default: iResultReady = 1'($urandom_range(0, 1));
    endcase
  end

  // Compare process: checks every cycle against the model queue.
  int   xferCount = 0;
  int   onesCount = 0;
  int   doneCount = 0;
  int   lastXferCyc = -10;
  int   doneCyc = -1;
  int   firstValidCyc = -1;
  logic held = 1'b0;
  logic prevDone = 1'b0;
  exp_t heldE;
  exp_t gotE;
  exp_t wantE;

  initial forever begin
    @(negedge clock);
    if (!not_reset) begin
      held     = 1'b0;
      prevDone = 1'b0;
    end else begin
      check(oImageCol == oThresholdCol && oImageRow == oThresholdRow, "addr_match",
            int'({oImageRow, oImageCol}), int'({oThresholdRow, oThresholdCol}));
      gotE = {oResultCol, oResultRow, oResultData};
      if (held) begin
        check(oResultValid && gotE == heldE, "head_stable", int'(gotE), int'(heldE));
      end
      held = 1'b0;
      if (oResultValid) begin
        if (firstValidCyc < 0) firstValidCyc = cyc;
        if (iResultReady) begin
          if (expQ.size() == 0) begin
            check(1'b0, "unexpected_pixel", int'(gotE), -1);
          end else begin
            wantE = expQ.pop_front();
            check(gotE == wantE, "pixel", int'(gotE), int'(wantE));
          end
          xferCount++;
          onesCount += int'(oResultData);
          lastXferCyc = cyc;
        end else begin
          held  = 1'b1;
          heldE = gotE;
        end
      end
      if (oDone) begin
        check(!prevDone && cyc == lastXferCyc + 1, "done_timing", cyc - lastXferCyc, 1);
        doneCount++;
        doneCyc = cyc;
      end
      prevDone = oDone;
    end
  end

  task automatic waitDone(input int base);
    int n;
    n = 0;
    while (doneCount == base && n < 400) begin
      @(posedge clock);
      n++;
    end
    check(doneCount > base, "done_timeout", doneCount - base, 1);
    #1;
    check(!oBusy && !oDone, "idle_after_done", int'({oBusy, oDone}), 0);
  endtask

  task automatic runFrame(input int c, input int mode, output int sCyc);
    int base;
    base      = doneCount;
    readyMode = mode;
    phase     = 0;
    queueFrame(c);
    @(posedge clock);
    #1;
    iC            = CB'(c);
    iStart        = 1'b1;
    sCyc          = cyc;
    firstValidCyc = -1;
    @(posedge clock);
    #1;
    iStart = 1'b0;
    iC     = CB'($urandom);
    check(oBusy == 1'b1, "busy_after_start", int'(oBusy), 1);
    waitDone(base);
    check(firstValidCyc == sCyc + 3, "first_valid_latency", firstValidCyc - sCyc, 3);
    check(expQ.size() == 0, "frame_complete", expQ.size(), 0);
    if (mode == 0) begin
      check(lastXferCyc == sCyc + 18, "throughput", lastXferCyc - sCyc, 18);
    end
  endtask

  initial begin
    int s;
    int ob;
    int base;
    int xb;
    int n;

    #1;
    check(outVec == '0, "reset_outputs", int'(outVec), 0);
    repeat (3) @(posedge clock);
    #3;
    not_reset = 1'b1;
    repeat (4) begin
      @(posedge clock);
      #1;
      check(!oResultValid && !oBusy, "idle_quiet", int'({oBusy, oResultValid}), 0);
    end

    // Start held high, C changed mid-frame: C=5 frame then C=6 frame back to back.
    for (int i = 0; i < N; i++) begin
      imgMem[i] = 8'd100;
      thrMem[i] = 8'd105;
    end
    queueFrame(5);
    queueFrame(6);
    readyMode = 0;
    base = doneCount;
    ob   = onesCount;
    @(posedge clock);
    #1;
    iC            = CB'(5);
    iStart        = 1'b1;
    s             = cyc;
    firstValidCyc = -1;
    repeat (8) @(posedge clock);
    #1;
    iC = CB'(6);
    waitDone(base);
    check(doneCyc == s + 19, "done_cycle_f1", doneCyc - s, 19);
    check(firstValidCyc == s + 3, "first_valid_f1", firstValidCyc - s, 3);
    check(onesCount - ob == OnesC5, "ones_c5", onesCount - ob, OnesC5);
    ob = onesCount;
    @(posedge clock);
    #1;
    iStart = 1'b0;
    waitDone(base + 1);
    check(doneCyc == s + 39, "done_cycle_f2", doneCyc - s, 39);
    check(onesCount - ob == OnesC6, "ones_c6", onesCount - ob, OnesC6);
    check(expQ.size() == 0, "held_frames_complete", expQ.size(), 0);

    // Saturating threshold: thr 3, C 31 -> adj 0; image alternates 0/1.
    for (int i = 0; i < N; i++) begin
      imgMem[i] = P'(i % 2);
      thrMem[i] = 8'd3;
    end
    ob = onesCount;
    runFrame(31, 0, s);
    check(onesCount - ob == 8, "ones_saturate", onesCount - ob, 8);

    // Ready pattern 1,0,0,1.
    fillRandom(255);
    xb = xferCount;
    runFrame(int'($urandom_range(0, 31)), 1, s);
    check(xferCount - xb == 16, "xfers_pattern", xferCount - xb, 16);

    // Reset after the seventh transfer, then a clean frame.
    fillRandom(60);
    queueFrame(9);
    readyMode = 0;
    xb = xferCount;
    @(posedge clock);
    #1;
    iC     = CB'(9);
    iStart = 1'b1;
    @(posedge clock);
    #1;
    iStart = 1'b0;
    n = 0;
    while (xferCount < xb + 7 && n < 100) begin
      @(posedge clock);
      n++;
    end
    check(xferCount == xb + 7, "seven_transfers", xferCount - xb, 7);
    #2;
    not_reset = 1'b0;
    #1;
    check(outVec == '0, "midframe_reset_outputs", int'(outVec), 0);
    expQ.delete();
    @(posedge clock);
    #3;
    not_reset = 1'b1;
    repeat (5) begin
      @(posedge clock);
      #1;
      check(!oResultValid && !oBusy, "quiet_after_reset", int'({oBusy, oResultValid}), 0);
    end
    xb = xferCount;
    runFrame(9, 0, s);
    check(xferCount - xb == 16, "xfers_after_reset", xferCount - xb, 16);

    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      fillRandom((f % 2 == 0) ? 255 : 40);
      xb = xferCount;
      runFrame(int'($urandom_range(0, 31)), f % 3, s);
      check(xferCount - xb == 16, "xfers_random", xferCount - xb, 16);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
